// File: rtl/galaksija_tape_ctrl.sv
// Galaksija tape playback controller.
// Captures the extent of a tape image written by the loader, then fetches it from SDRAM one byte
// at a time. Each byte goes out as a pulse-coded bit stream (8 slots per bit, LSB first),
// followed by an idle-high gap.
// Optional feature: define TAPE_PAUSE_EN to let the pause input freeze playback.
module galaksija_tape_ctrl #(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned SLOT_CYCLES = 1150,
    parameter int unsigned GAP_CYCLES  = 13000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic              tick_en,
    input  logic              pause,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [7:0]        rd_data,
    output logic              tape_bit,
    output logic              active,
    output logic [ADDR_W-1:0] read_pos,
    output logic [ADDR_W-1:0] addr_max
);

    // One timer serves both slot and gap timing, so size it for the longer of the two.
    localparam int unsigned TmrMax = (GAP_CYCLES > SLOT_CYCLES) ? GAP_CYCLES : SLOT_CYCLES;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);
    localparam logic [TmrW-1:0] SlotLast = TmrW'(SLOT_CYCLES - 1);
    localparam logic [TmrW-1:0] GapLast  = TmrW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPlay,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic              dl_q, dl_d;
    logic              have_data_q, have_data_d;
    logic [ADDR_W-1:0] addr_max_q, addr_max_d;
    logic [ADDR_W-1:0] read_pos_q, read_pos_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              tape_bit_q, tape_bit_d;
    logic              active_q, active_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [2:0]        slot_q, slot_d;
    logic [TmrW-1:0]   timer_q, timer_d;

    logic freeze;
    logic adv;
    logic dl_rise;
    logic dl_fall;

`ifdef TAPE_PAUSE_EN
    assign freeze = pause;
`else
    // pause has no effect in this build.
    logic unused_pause;
    assign unused_pause = pause;
    assign freeze       = 1'b0;
`endif

    assign adv     = tick_en & ~freeze;
    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;

    // Next-state: capture, fetch handshake, slot/bit sequencing and gap timing.
    always_comb begin
        state_d     = state_q;
        dl_d        = ioctl_download;
        have_data_d = have_data_q;
        addr_max_d  = addr_max_q;
        read_pos_d  = read_pos_q;
        rd_req_d    = rd_req_q;
        rd_addr_d   = rd_addr_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        slot_d      = slot_q;
        timer_d     = timer_q;

        unique case (state_q)
            StIdle: begin
                rd_req_d = 1'b0;
            end
            StLoad: begin
                rd_req_d  = 1'b1;
                rd_addr_d = read_pos_q;
                // Ack is honoured even while paused; playback then starts frozen.
                if (rd_ack && rd_req_q) begin
                    shift_d   = rd_data;
                    rd_req_d  = 1'b0;
                    bit_idx_d = 3'd0;
                    slot_d    = 3'd0;
                    timer_d   = '0;
                    state_d   = StPlay;
                end
            end
            StPlay: begin
                if (adv) begin
                    if (timer_q == SlotLast) begin
                        timer_d = '0;
                        slot_d  = slot_q + 3'd1;
                        if (slot_q == 3'd7) begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
                                state_d = StGap;
                            end
                        end
                    end else begin
                        timer_d = timer_q + TmrW'(1);
                    end
                end
            end
            StGap: begin
                if (adv) begin
                    if (timer_q == GapLast) begin
                        timer_d = '0;
                        if (read_pos_q == addr_max_q) begin
                            state_d = StIdle;
                        end else begin
                            read_pos_d = read_pos_q + ADDR_W'(1);
                            rd_addr_d  = read_pos_q + ADDR_W'(1);
                            rd_req_d   = 1'b1;
                            state_d    = StLoad;
                        end
                    end else begin
                        timer_d = timer_q + TmrW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // End of a download starts playback from the first byte if anything was written.
        if (dl_fall && have_data_q) begin
            read_pos_d = '0;
            rd_addr_d  = '0;
            rd_req_d   = 1'b1;
            state_d    = StLoad;
        end

        // A new download aborts playback; a concurrent read ack is discarded.
        if (dl_rise) begin
            state_d     = StIdle;
            rd_req_d    = 1'b0;
            timer_d     = '0;
            addr_max_d  = '0;
            have_data_d = 1'b0;
        end

        if (ioctl_download && ioctl_wr) begin
            addr_max_d  = ioctl_addr;
            have_data_d = 1'b1;
        end
    end

    // Registered outputs derived from the next state so they align with state changes.
    always_comb begin
        active_d   = (state_d != StIdle);
        tape_bit_d = 1'b1;
        if (state_d == StPlay) begin
            if (slot_d == 3'd0) begin
                tape_bit_d = 1'b0;
            end else if (slot_d == 3'd4 && shift_d[bit_idx_d]) begin
                tape_bit_d = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            dl_q        <= 1'b0;
            have_data_q <= 1'b0;
            addr_max_q  <= '0;
            read_pos_q  <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            tape_bit_q  <= 1'b1;
            active_q    <= 1'b0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            slot_q      <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            dl_q        <= dl_d;
            have_data_q <= have_data_d;
            addr_max_q  <= addr_max_d;
            read_pos_q  <= read_pos_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            tape_bit_q  <= tape_bit_d;
            active_q    <= active_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            slot_q      <= slot_d;
            timer_q     <= timer_d;
        end
    end

    assign rd_req   = rd_req_q;
    assign rd_addr  = rd_addr_q;
    assign tape_bit = tape_bit_q;
    assign active   = active_q;
    assign read_pos = read_pos_q;
    assign addr_max = addr_max_q;

endmodule

// File: tb/tb_galaksija_tape_ctrl.sv
// Directed bench for galaksija_tape_ctrl with short slot/gap timing and a small SDRAM model.
module tb_galaksija_tape_ctrl;

    localparam int ADDR_W = 14;
    localparam int SLOT   = 4;
    localparam int GAP    = 8;
    localparam int BYTE_N = 64 * SLOT + GAP;  // 264 enabled cycles per byte
    localparam int LAT    = 2;

    logic              clk;
    logic              reset;
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic              tick_en;
    logic              pause;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [7:0]        rd_data;
    logic              tape_bit;
    logic              active;
    logic [ADDR_W-1:0] read_pos;
    logic [ADDR_W-1:0] addr_max;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [4];
    int  ack_kick = 0;
    int  ack_seen;
    int  lat;
    bit  ack_en = 1'b1;

    galaksija_tape_ctrl #(
        .ADDR_W     (ADDR_W),
        .SLOT_CYCLES(SLOT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .tick_en       (tick_en),
        .pause         (pause),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_ack        (rd_ack),
        .rd_data       (rd_data),
        .tape_bit      (tape_bit),
        .active        (active),
        .read_pos      (read_pos),
        .addr_max      (addr_max)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SDRAM model: acks LAT negedges after seeing rd_req, or on demand via ack_kick.
    initial begin
        rd_ack   = 1'b0;
        rd_data  = 8'h00;
        lat      = 0;
        ack_seen = 0;
        forever begin
            @(negedge clk);
            if (rd_ack) begin
                rd_ack = 1'b0;
            end else if (ack_kick != ack_seen) begin
                ack_seen = ack_kick;
                rd_ack   = 1'b1;
                rd_data  = mem[rd_addr[1:0]];
                lat      = 0;
            end else if (ack_en && rd_req) begin
                if (lat == LAT) begin
                    rd_ack  = 1'b1;
                    rd_data = mem[rd_addr[1:0]];
                    lat     = 0;
                end else begin
                    lat++;
                end
            end else begin
                lat = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected tape level after n enabled cycles since the ack edge.
    function automatic logic exp_bit(input logic [7:0] b, input int n);
        int bi;
        int sl;
        if (n >= 64 * SLOT) return 1'b1;
        bi = n / (8 * SLOT);
        sl = (n / SLOT) % 8;
        if (sl == 0) return 1'b0;
        if (sl == 4 && b[bi]) return 1'b0;
        return 1'b1;
    endfunction

    // Waits for the read ack, then follows one byte until stop_n enabled cycles have passed.
    // mode 0: tick_en high; mode 1: tick_en every other cycle (low while loading);
    // mode 2: tick_en high, pause high for 100 cycles starting 50 cycles into the byte.
    task automatic play_byte(input logic [7:0] b, input int mode, input int stop_n,
                             input int exp_cyc, input string name);
        int   guard;
        int   n;
        int   c;
        int   werr;
        int   first_bad;
        logic adv;
        guard   = 0;
        pause   = 1'b0;
        tick_en = (mode != 1);
        while (rd_ack !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        checks++;
        if (rd_ack !== 1'b1) begin
            errors++;
            $display("FAIL %s ack_wait: no read ack within %0d cycles (rd_req=%b)", name, guard,
                     rd_req);
            tick_en = 1'b1;
            return;
        end
        n         = 0;
        c         = 0;
        werr      = 0;
        first_bad = -1;
        while (n < stop_n && c < 2000) begin
            if (tape_bit !== exp_bit(b, n)) begin
                werr++;
                if (first_bad < 0) first_bad = n;
            end
            tick_en = (mode == 1) ? (c % 2 == 1) : 1'b1;
            pause   = (mode == 2) && (c >= 50) && (c < 150);
`ifdef TAPE_PAUSE_EN
            adv = tick_en && !pause;
`else
            adv = tick_en;
`endif
            step();
            if (adv) n++;
            c++;
        end
        tick_en = 1'b1;
        pause   = 1'b0;
        checks++;
        if (werr != 0) begin
            errors++;
            $display("FAIL %s waveform: %0d wrong tape_bit samples, first at enabled cycle %0d, want 0",
                     name, werr, first_bad);
        end
        checks++;
        if (c != exp_cyc) begin
            errors++;
            $display("FAIL %s duration: took %0d cycles, want %0d", name, c, exp_cyc);
        end
    endtask

    task automatic do_download(input int nbytes);
        ioctl_download = 1'b1;
        step();
        for (int i = 0; i < nbytes; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = ADDR_W'(i);
            step();
            ioctl_wr = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        checks++;
        if (tape_bit !== 1'b1) begin errors++; $display("FAIL reset tape_bit: got %b want 1", tape_bit); end
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL reset active: got %b want 0", active); end
        checks++;
        if (rd_req !== 1'b0) begin errors++; $display("FAIL reset rd_req: got %b want 0", rd_req); end
        checks++;
        if (rd_addr !== '0) begin errors++; $display("FAIL reset rd_addr: got %0h want 0", rd_addr); end
        checks++;
        if (read_pos !== '0) begin errors++; $display("FAIL reset read_pos: got %0h want 0", read_pos); end
        checks++;
        if (addr_max !== '0) begin errors++; $display("FAIL reset addr_max: got %0h want 0", addr_max); end
    endtask

    task automatic test_load_three();
        int exp_pause;
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        mem[2] = 8'hFF;
        do_download(3);
        checks++;
        if (addr_max !== 14'd2) begin errors++; $display("FAIL load addr_max: got %0d want 2", addr_max); end
        checks++;
        if (rd_req !== 1'b0) begin errors++; $display("FAIL load rd_req_during_dl: got %b want 0", rd_req); end
        ioctl_download = 1'b0;
        step();
        checks++;
        if (rd_req !== 1'b1) begin errors++; $display("FAIL load rd_req_rise: got %b want 1", rd_req); end
        checks++;
        if (rd_addr !== 14'd0) begin errors++; $display("FAIL load rd_addr0: got %0d want 0", rd_addr); end
        checks++;
        if (active !== 1'b1 || tape_bit !== 1'b1) begin
            errors++;
            $display("FAIL load active/tape: got %b/%b want 1/1", active, tape_bit);
        end
        play_byte(8'hA5, 0, BYTE_N, BYTE_N, "byte0_a5");
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== 14'd1 || read_pos !== 14'd1) begin
            errors++;
            $display("FAIL byte0 next_load: got rd_req=%b rd_addr=%0d read_pos=%0d want 1/1/1",
                     rd_req, rd_addr, read_pos);
        end
        play_byte(8'h3C, 1, BYTE_N, 2 * BYTE_N, "byte1_tick_half");
        checks++;
        if (rd_addr !== 14'd2 || read_pos !== 14'd2) begin
            errors++;
            $display("FAIL byte1 next_load: got rd_addr=%0d read_pos=%0d want 2/2", rd_addr, read_pos);
        end
`ifdef TAPE_PAUSE_EN
        exp_pause = BYTE_N + 100;
`else
        exp_pause = BYTE_N;
`endif
        play_byte(8'hFF, 2, BYTE_N, exp_pause, "byte2_pause");
        checks++;
        if (active !== 1'b0 || rd_req !== 1'b0 || tape_bit !== 1'b1) begin
            errors++;
            $display("FAIL end idle: got active=%b rd_req=%b tape_bit=%b want 0/0/1",
                     active, rd_req, tape_bit);
        end
        checks++;
        if (read_pos !== 14'd2 || addr_max !== 14'd2) begin
            errors++;
            $display("FAIL end counters: got read_pos=%0d addr_max=%0d want 2/2", read_pos, addr_max);
        end
    endtask

    task automatic test_stray_ack();
        ack_kick++;
        step();
        step();
        checks++;
        if (active !== 1'b0 || rd_req !== 1'b0 || read_pos !== 14'd2) begin
            errors++;
            $display("FAIL stray_ack: got active=%b rd_req=%b read_pos=%0d want 0/0/2",
                     active, rd_req, read_pos);
        end
    endtask

    task automatic test_abort_gap();
        mem[0] = 8'h81;
        mem[1] = 8'h42;
        do_download(2);
        checks++;
        if (addr_max !== 14'd1) begin errors++; $display("FAIL gap_abort addr_max: got %0d want 1", addr_max); end
        ioctl_download = 1'b0;
        step();
        play_byte(8'h81, 0, 64 * SLOT + 2, 64 * SLOT + 2, "gap_abort_byte");
        ioctl_download = 1'b1;
        step();
        checks++;
        if (active !== 1'b0 || rd_req !== 1'b0 || tape_bit !== 1'b1) begin
            errors++;
            $display("FAIL gap_abort idle: got active=%b rd_req=%b tape_bit=%b want 0/0/1",
                     active, rd_req, tape_bit);
        end
        checks++;
        if (addr_max !== 14'd0) begin errors++; $display("FAIL gap_abort addr_clr: got %0d want 0", addr_max); end
        ioctl_download = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (rd_req !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL empty_dl stays_idle: got rd_req=%b active=%b want 0/0", rd_req, active);
        end
    endtask

    task automatic test_abort_ack();
        mem[0] = 8'h55;
        ack_en = 1'b0;
        do_download(1);
        ioctl_download = 1'b0;
        step();
        step();
        step();
        checks++;
        if (rd_req !== 1'b1) begin errors++; $display("FAIL ack_abort rd_req_hold: got %b want 1", rd_req); end
        ioctl_download = 1'b1;
        ack_kick++;
        step();
        checks++;
        if (active !== 1'b0 || rd_req !== 1'b0 || tape_bit !== 1'b1) begin
            errors++;
            $display("FAIL ack_abort idle: got active=%b rd_req=%b tape_bit=%b want 0/0/1",
                     active, rd_req, tape_bit);
        end
        ioctl_download = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (rd_req !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL ack_abort no_restart: got rd_req=%b active=%b want 0/0", rd_req, active);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid_play();
        mem[0] = 8'h00;
        mem[1] = 8'h00;
        do_download(2);
        ioctl_download = 1'b0;
        step();
        play_byte(8'h00, 0, BYTE_N, BYTE_N, "rst_byte0");
        play_byte(8'h00, 0, 8 * SLOT + 1, 8 * SLOT + 1, "rst_byte1");
        checks++;
        if (tape_bit !== 1'b0 || read_pos !== 14'd1 || active !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got tape_bit=%b read_pos=%0d active=%b want 0/1/1",
                     tape_bit, read_pos, active);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (tape_bit !== 1'b1 || active !== 1'b0 || rd_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset outs: got tape_bit=%b active=%b rd_req=%b want 1/0/0",
                     tape_bit, active, rd_req);
        end
        checks++;
        if (read_pos !== '0 || addr_max !== '0 || rd_addr !== '0) begin
            errors++;
            $display("FAIL async_reset counters: got read_pos=%0d addr_max=%0d rd_addr=%0d want 0/0/0",
                     read_pos, addr_max, rd_addr);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        tick_en        = 1'b1;
        pause          = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        step();
        step();
        test_reset();
        reset = 1'b0;
        step();
        test_load_three();
        test_stray_ack();
        test_abort_gap();
        test_abort_ack();
        test_reset_mid_play();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
